// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a carry flop, LSB first
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : request, accepted in IDLE or DONE
//   a, b, ci       : operands and carry-in, captured on the accepting edge
//   busy           : high while bits are being added
//   done           : one-cycle pulse when sum/co are updated
//   sum, co        : registered result, held until the next result
//   ovf            : two's-complement overflow, present only with SERIAL_ADDER_OVF_EN
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic [CW-1:0] cnt;
    logic c, bit_s, c_nxt;
    assign bit_s = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= {bit_s, s_sh[WIDTH-1:1]};
                    c    <= c_nxt;
                    // the last bit goes straight into sum so the result lands on this edge
                    if (cnt == LAST) begin
                        sum   <= {bit_s, s_sh[WIDTH-1:1]};
                        co    <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= c ^ c_nxt;
`endif
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8), directed vectors
module tb_serial_adder;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ci = 1'b0;
    logic       busy, done, co;
    logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`else
    logic       ovf;
    assign ovf = 1'b0;
`endif
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    serial_adder #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .ci(ci),
        .busy(busy),
        .done(done),
        .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .co(co)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("busy_with_done", {31'd0, busy}, 32'd0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e.s});
                check("co", {31'd0, co}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, e.v});
`endif
            end
        end
    end
    task automatic push(input logic [7:0] s, input logic c, input logic v);
        exp_t e;
        e.s = s;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        a = x;
        b = y;
        ci = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    // called at the negedge after the accepting edge; edges counts that edge as 1
    task automatic wait_done(output int edges, output int bc);
        edges = 1;
        bc = 0;
        while (!done && edges < 40) begin
            if (busy) bc++;
            @(negedge clk);
            edges++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d edges expected done", edges);
        end
    endtask
    task automatic run(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic [7:0] es, input logic ec, input logic ev);
        int edges, bc;
        push(es, ec, ev);
        issue(x, y, c);
        wait_done(edges, bc);
        check("latency_edges", edges, 32'd9);
        check("busy_cycles", bc, 32'd8);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask
    initial begin
        int edges, bc, cyc, last, nd;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_co", {31'd0, co}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        run(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        // second request lands mid-ADD and must vanish
        push(8'h30, 1'b0, 1'b0);
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        issue(8'hAA, 8'h55, 1'b0);
        wait_done(edges, bc);
        repeat (15) @(negedge clk);
        // abort mid-operation with an asynchronous reset
        issue(8'h0F, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_co", {31'd0, co}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        run(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        // start held high: one result every 9 cycles, busy low only with done
        push(8'h03, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        ci = 1'b1;
        start = 1'b1;
        cyc = 0;
        last = 0;
        nd = 0;
        while (nd < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            check("b2b_busy", {31'd0, busy}, {31'd0, ~done});
            if (done) begin
                if (nd > 0) check("b2b_period", cyc - last, 32'd9);
                last = cyc;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_results", nd, 32'd3);
        repeat (15) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
